// File: rtl/io_bus_pkg.sv
// Shared constants for the io_bus interconnect: I/O base word address,
// I/O register offsets and the registered read-select encoding.
package io_bus_pkg;

    localparam logic [29:0] IO_BASE = 30'h4000;

    localparam logic [3:0] OFF_TX       = 4'd0;
    localparam logic [3:0] OFF_RX       = 4'd1;
    localparam logic [3:0] OFF_MS       = 4'd2;
    localparam logic [3:0] OFF_GPIO_OUT = 4'd3;
    localparam logic [3:0] OFF_GPIO_SET = 4'd4;
    localparam logic [3:0] OFF_GPIO_CLR = 4'd5;
    localparam logic [3:0] OFF_GPIO_TGL = 4'd6;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd7;
    localparam logic [3:0] OFF_CMP      = 4'd8;
    localparam logic [3:0] OFF_IRQ      = 4'd9;
    localparam logic [3:0] OFF_ERR      = 4'd10;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_IO
    } sel_e;

    // Expand byte-lane write enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/io_bus_sync2.sv
// Parametrised-width two-flop synchroniser with asynchronous reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    // Next values: each stage samples the one before it.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser stages, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/io_bus.sv
// CPU data-port interconnect: decodes RAM vs. memory-mapped I/O, drives
// RAM/UART strobes, holds GPIO/CMP/IRQ registers and returns read data one
// cycle after re. Optional unmapped-access capture register enabled by the
// IO_BUS_ERR_EN macro.
module io_bus
    import io_bus_pkg::*;
#(
    parameter int                NUM_WORDS  = 3584,
    parameter int                GPIO_W     = 8,
    parameter logic [GPIO_W-1:0] GPIO_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [3:0]        we,
    output logic [31:0]       rdata,
    output logic              ram_re,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              uart_wr,
    output logic              uart_rd,
    input  logic [7:0]        uart_rdata,
    input  logic              rx_empty,
    input  logic              tx_full,
    input  logic [31:0]       ms_count,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam logic [29:0] RAM_LIMIT = 30'(NUM_WORDS);

    logic              is_ram, is_io, io_wr;
    logic [3:0]        off;
    logic [31:0]       wmask;
    logic [GPIO_W-1:0] gmask, gdata, gpio_sync;
    logic [31:0]       io_rdata;

    sel_e              sel_q, sel_d;
    logic [3:0]        off_q, off_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       cmp_q, cmp_d;
    logic [31:0]       ms_prev_q, ms_prev_d;
    logic              irq_q, irq_d;
    logic              uart_rd_q, uart_rd_d;

    assign is_ram = addr < RAM_LIMIT;
    assign is_io  = addr[29:4] == IO_BASE[29:4];
    assign off    = addr[3:0];
    assign io_wr  = is_io & (|we);
    assign wmask  = lane_mask(we);
    assign gmask  = wmask[GPIO_W-1:0];
    assign gdata  = wdata[GPIO_W-1:0] & gmask;

    assign ram_re   = re & is_ram;
    assign ram_we   = is_ram ? we : 4'b0;
    assign uart_wr  = is_io & (off == OFF_TX) & (we == 4'hF);
    assign uart_rd  = uart_rd_q;
    assign gpio_out = gpio_q;
    assign irq      = irq_q;

    sync2 #(.W(GPIO_W)) u_gpio_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_in),
        .q     (gpio_sync)
    );

    // Next state for read select, GPIO, compare and interrupt registers.
    always_comb begin
        sel_d     = SEL_NONE;
        off_d     = off;
        uart_rd_d = re & is_io & (off == OFF_RX);
        gpio_d    = gpio_q;
        cmp_d     = cmp_q;
        ms_prev_d = ms_count;
        irq_d     = irq_q;
        if (re) begin
            if (is_ram)     sel_d = SEL_RAM;
            else if (is_io) sel_d = SEL_IO;
        end
        if (io_wr) begin
            case (off)
                OFF_GPIO_OUT: gpio_d = (gpio_q & ~gmask) | gdata;
                OFF_GPIO_SET: gpio_d = gpio_q | gdata;
                OFF_GPIO_CLR: gpio_d = gpio_q & ~gdata;
                OFF_GPIO_TGL: gpio_d = gpio_q ^ gdata;
                OFF_CMP:      cmp_d  = (cmp_q & ~wmask) | (wdata & wmask);
                OFF_IRQ:      if (we[0] && wdata[0]) irq_d = 1'b0;
                default:      ;
            endcase
        end
        // Only a fresh match sets irq, so clearing it during a static match sticks.
        if ((ms_count != ms_prev_q) && (ms_count == cmp_q)) irq_d = 1'b1;
    end

    // Main register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= SEL_NONE;
            off_q     <= '0;
            uart_rd_q <= 1'b0;
            gpio_q    <= GPIO_RESET;
            cmp_q     <= 32'hFFFF_FFFF;
            ms_prev_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            off_q     <= off_d;
            uart_rd_q <= uart_rd_d;
            gpio_q    <= gpio_d;
            cmp_q     <= cmp_d;
            ms_prev_q <= ms_prev_d;
            irq_q     <= irq_d;
        end
    end

`ifdef IO_BUS_ERR_EN
    logic        unmapped;
    logic        err_flag_q, err_flag_d;
    logic [29:0] err_addr_q, err_addr_d;

    assign unmapped = (re | (|we)) & ~is_ram & ~(is_io & (off <= OFF_ERR));

    // Sticky capture of the first unmapped access; any write to ERR clears the flag.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (io_wr && (off == OFF_ERR)) begin
            err_flag_d = 1'b0;
        end else if (unmapped && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = addr;
        end
    end

    // Error capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end
`endif

    // Read data mux on the select captured in the previous cycle.
    always_comb begin
        io_rdata = '0;
        case (off_q)
            OFF_TX:       io_rdata = {31'b0, tx_full};
            OFF_RX:       io_rdata = {23'b0, rx_empty, uart_rdata};
            OFF_MS:       io_rdata = ms_count;
            OFF_GPIO_OUT,
            OFF_GPIO_SET,
            OFF_GPIO_CLR,
            OFF_GPIO_TGL: io_rdata = 32'(gpio_q);
            OFF_GPIO_IN:  io_rdata = 32'(gpio_sync);
            OFF_CMP:      io_rdata = cmp_q;
            OFF_IRQ:      io_rdata = {31'b0, irq_q};
`ifdef IO_BUS_ERR_EN
            OFF_ERR:      io_rdata = {err_flag_q, 1'b0, err_addr_q};
`endif
            default:      io_rdata = '0;
        endcase
        rdata = '0;
        case (sel_q)
            SEL_RAM: rdata = ram_rdata;
            SEL_IO:  rdata = io_rdata;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_io_bus.sv
// Directed self-checking bench for io_bus with a small behavioural RAM that
// has a one-cycle output register. Inputs change on the falling edge;
// outputs are checked on the falling edge or #1 after an input change.
module tb_io_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        ram_re;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic        uart_wr;
    logic        uart_rd;
    logic [7:0]  uart_rdata;
    logic        rx_empty;
    logic        tx_full;
    logic [31:0] ms_count;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_bus dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .re         (re),
        .we         (we),
        .rdata      (rdata),
        .ram_re     (ram_re),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .uart_wr    (uart_wr),
        .uart_rd    (uart_rd),
        .uart_rdata (uart_rdata),
        .rx_empty   (rx_empty),
        .tx_full    (tx_full),
        .ms_count   (ms_count),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .irq        (irq)
    );

    // RAM model with registered output.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_re) ram_rdata <= mem[addr[5:0]];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[addr[5:0]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr = a; wdata = d; we = w; re = 1'b0;
        @(negedge clk);
        we = 4'h0;
    endtask

    task automatic rd(input logic [29:0] a);
        @(negedge clk);
        addr = a; re = 1'b1; we = 4'h0;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        addr = '0; wdata = '0; re = 1'b0; we = 4'h0;
        uart_rdata = '0; rx_empty = 1'b1; tx_full = 1'b0;
        ms_count = '0; gpio_in = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpio got %h want 00", gpio_out); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        n_checks++; if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL reset_uart_rd got %b want 0", uart_rd); end
        reset = 1'b0;
        rd(30'h4008);
        n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp got %h want ffffffff", rdata); end
    endtask

    task automatic test_ram;
        @(negedge clk);
        addr = 30'h3; wdata = 32'h0000_00A5; we = 4'h1;
        #1;
        n_checks++; if (ram_we !== 4'h1) begin n_fail++; $display("FAIL ram_we got %h want 1", ram_we); end
        @(negedge clk);
        we = 4'h0;
        rd(30'h3);
        n_checks++; if (rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL ram_read got %h want 000000a5", rdata); end
        @(negedge clk);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata got %h want 0", rdata); end
        addr = 30'd3583; we = 4'hF; wdata = 32'h1234_5678;
        #1;
        n_checks++; if (ram_we !== 4'hF) begin n_fail++; $display("FAIL ram_top_we got %h want f", ram_we); end
        addr = 30'd3584;
        #1;
        n_checks++; if (ram_we !== 4'h0) begin n_fail++; $display("FAIL ram_limit_we got %h want 0", ram_we); end
        @(negedge clk);
        we = 4'h0;
    endtask

    task automatic test_gpio;
        wr(30'h4003, 32'h0000_00A5, 4'hF);
        n_checks++; if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_out got %h want a5", gpio_out); end
        wr(30'h4004, 32'h0000_000F, 4'hF);
        n_checks++; if (gpio_out !== 8'hAF) begin n_fail++; $display("FAIL gpio_set got %h want af", gpio_out); end
        wr(30'h4005, 32'h0000_0081, 4'hF);
        n_checks++; if (gpio_out !== 8'h2E) begin n_fail++; $display("FAIL gpio_clr got %h want 2e", gpio_out); end
        wr(30'h4006, 32'h0000_00FF, 4'hF);
        n_checks++; if (gpio_out !== 8'hD1) begin n_fail++; $display("FAIL gpio_tgl got %h want d1", gpio_out); end
        wr(30'h4003, 32'h0000_00FF, 4'h2);
        n_checks++; if (gpio_out !== 8'hD1) begin n_fail++; $display("FAIL gpio_lane got %h want d1", gpio_out); end
        rd(30'h4005);
        n_checks++; if (rdata !== 32'h0000_00D1) begin n_fail++; $display("FAIL gpio_readback got %h want 000000d1", rdata); end
    endtask

    task automatic test_back_to_back_gpio_in;
        gpio_in = 8'h3C;
        repeat (3) @(negedge clk);
        gpio_in = 8'h5A; addr = 30'h4007; re = 1'b1;
        @(negedge clk);
        n_checks++; if (rdata !== 32'h0000_003C) begin n_fail++; $display("FAIL gpio_in_sync1 got %h want 0000003c", rdata); end
        @(negedge clk);
        re = 1'b0;
        n_checks++; if (rdata !== 32'h0000_005A) begin n_fail++; $display("FAIL gpio_in_sync2 got %h want 0000005a", rdata); end
    endtask

    task automatic test_uart;
        @(negedge clk);
        addr = 30'h4000; wdata = 32'h55; we = 4'hF;
        #1;
        n_checks++; if (uart_wr !== 1'b1) begin n_fail++; $display("FAIL uart_wr_full got %b want 1", uart_wr); end
        we = 4'h1;
        #1;
        n_checks++; if (uart_wr !== 1'b0) begin n_fail++; $display("FAIL uart_wr_partial got %b want 0", uart_wr); end
        we = 4'h0;
        tx_full = 1'b1;
        rd(30'h4000);
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL uart_status got %h want 1", rdata); end
        tx_full = 1'b0;
        @(negedge clk);
        addr = 30'h4001; re = 1'b1; rx_empty = 1'b0; uart_rdata = 8'h41;
        #1;
        n_checks++; if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL uart_rd_early got %b want 0", uart_rd); end
        @(negedge clk);
        re = 1'b0;
        n_checks++; if (rdata !== 32'h0000_0041) begin n_fail++; $display("FAIL uart_rx got %h want 00000041", rdata); end
        n_checks++; if (uart_rd !== 1'b1) begin n_fail++; $display("FAIL uart_rd_pulse got %b want 1", uart_rd); end
        @(negedge clk);
        n_checks++; if (uart_rd !== 1'b0) begin n_fail++; $display("FAIL uart_rd_end got %b want 0", uart_rd); end
        rx_empty = 1'b1;
        rd(30'h4001);
        n_checks++; if (rdata !== 32'h0000_0141) begin n_fail++; $display("FAIL uart_rx_empty got %h want 00000141", rdata); end
    endtask

    task automatic test_irq;
        ms_count = 32'd4;
        wr(30'h4008, 32'd5, 4'hF);
        @(negedge clk);
        ms_count = 32'd5;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b want 1", irq); end
        rd(30'h4009);
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL irq_read got %h want 1", rdata); end
        wr(30'h4009, 32'h1, 4'h1);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
        repeat (2) @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_static got %b want 0", irq); end
        ms_count = 32'd6;
        @(negedge clk);
        ms_count = 32'd5;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_reset got %b want 1", irq); end
        wr(30'h4009, 32'h1, 4'h1);
        ms_count = 32'd6;
        @(negedge clk);
        ms_count = 32'd5; addr = 30'h4009; wdata = 32'h1; we = 4'h1;
        @(negedge clk);
        we = 4'h0;
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got %b want 1", irq); end
        wr(30'h4008, 32'hAABB_CCDD, 4'h4);
        rd(30'h4008);
        n_checks++; if (rdata !== 32'h00BB_0005) begin n_fail++; $display("FAIL cmp_lane got %h want 00bb0005", rdata); end
        rd(30'h4002);
        n_checks++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL ms_read got %h want 5", rdata); end
    endtask

    task automatic test_unmapped;
        wr(30'h400A, 32'h0, 4'hF);
        rd(30'h4020);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd got %h want 0", rdata); end
        rd(30'h400C);
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_off_rd got %h want 0", rdata); end
        wr(30'h4024, 32'hFF, 4'hF);
        n_checks++; if (gpio_out !== 8'hD1) begin n_fail++; $display("FAIL unmapped_wr got %h want d1", gpio_out); end
        rd(30'h400A);
`ifdef IO_BUS_ERR_EN
        n_checks++; if (rdata !== 32'h8000_4020) begin n_fail++; $display("FAIL err_capture got %h want 80004020", rdata); end
        wr(30'h400A, 32'h0, 4'hF);
        rd(30'h400A);
        n_checks++; if (rdata !== 32'h0000_4020) begin n_fail++; $display("FAIL err_clear got %h want 00004020", rdata); end
`else
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL err_absent got %h want 0", rdata); end
`endif
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        addr = 30'h10; re = 1'b1;
        @(posedge clk);
        #2;
        re = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL rst_gpio got %h want 00", gpio_out); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", rdata); end
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata_next got %h want 0", rdata); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_back_to_back_gpio_in();
        test_uart();
        test_irq();
        test_unmapped();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus.md
# io_bus

Memory-mapped I/O interconnect between the CPU data port and RAM, UART, millisecond counter, GPIO and a timer-compare interrupt. It decodes each word address to RAM or one I/O register and issues RAM/UART strobes. It returns read data with the same one-cycle latency as the RAM output register. It generalises the single-bit output latch into a parametrised GPIO bank with set/clear/toggle and synchronised inputs.

## Interface
- `NUM_WORDS`, 3584: RAM size in 32-bit words; word addresses below this value select RAM.
- `GPIO_W`, 8: GPIO width, 1..32.
- `GPIO_RESET`, 0: reset value of `gpio_out`; `GPIO_W` bits.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `addr` in 30: CPU word address.
- `wdata` in 32: CPU write data.
- `re` in 1: CPU read strobe.
- `we` in 4: CPU byte-lane write enables.
- `rdata` out 32: read data, valid the cycle after `re`.
- `ram_re` out 1: RAM read enable.
- `ram_we` out 4: RAM byte-lane write enables.
- `ram_rdata` in 32: RAM output-register data.
- `uart_wr` out 1: UART TX push.
- `uart_rd` out 1: UART RX pop, delayed one cycle.
- `uart_rdata` in 8: UART RX data.
- `rx_empty` in 1: UART RX FIFO empty.
- `tx_full` in 1: UART TX FIFO full.
- `ms_count` in 32: millisecond counter.
- `gpio_in` in `GPIO_W`: asynchronous GPIO inputs.
- `gpio_out` out `GPIO_W`: GPIO output register.
- `irq` out 1: timer-compare interrupt pending, level output.

## Operation
- Region decode: `addr < NUM_WORDS` selects RAM. Word addresses 0x4000–0x400F select I/O (byte 0x10000). All other addresses are unmapped.
- RAM strobes: `ram_re = re & ram`; `ram_we = ram ? we : 0`.
- I/O map, word offsets from 0x4000:
  - 0 TX / status: read `{31'b0, tx_full}`; write with `we==4'hF` pulses `uart_wr`.
  - 1 RX: read `{23'b0, rx_empty, uart_rdata}`; a read pulses `uart_rd` one cycle later.
  - 2 MS: read `ms_count`.
  - 3 GPIO_OUT: read/write; byte-lane masked.
  - 4 GPIO_SET: `gpio_out |= wdata`, byte-lane masked.
  - 5 GPIO_CLR: `gpio_out &= ~wdata`, byte-lane masked.
  - 6 GPIO_TGL: `gpio_out ^= wdata`, byte-lane masked.
  - 7 GPIO_IN: read-only; synchronised inputs, zero-extended.
  - 8 CMP: read/write, 32-bit, byte-lane masked.
  - 9 IRQ: read `{31'b0, irq}`; writing 1 to bit 0 with `we[0]` clears it.
  - 10 ERR: present only under `IO_BUS_ERR_EN`.
- Offsets 3–6 read back `gpio_out`.
- Unmapped reads return 0. Unmapped writes are dropped. Offsets above 10 are unmapped; there is no mirroring.
- Timer compare: `irq` sets when `ms_count` changes and its new value equals CMP. This is edge-qualified, so a static match does not re-set `irq` after it is cleared.
- IRQ set and clear in the same cycle: set wins.
- GPIO inputs pass through a 2-flop synchroniser before being read at offset 7.

## Timing
- Decode and strobes are combinational in the `re`/`we` cycle.
- Register writes take effect at the next clock edge.
- Read path: a registered read-select (RAM, I/O offset, or none) is captured on `re`. `rdata` is a combinational mux on that select in the following cycle.
- Read data sources: I/O register values are sampled from the cycle-after state. `ms_count` is the value in that cycle.
- When `re` was low in the previous cycle, the select is none and `rdata` = 0.
- Back-to-back reads are allowed every cycle; each returns one cycle later.
- `uart_rd` is high for exactly one cycle, the cycle after an RX read.
- `gpio_in` to offset-7 readback: 2 cycles of synchroniser latency.
- Reset, asynchronous:
  - Outputs and state: `gpio_out = GPIO_RESET`, CMP = 0xFFFFFFFF, `irq` = 0, select = none, `rdata` = 0, `uart_rd` = 0.
  - Synchroniser flops and the ERR register clear.
  - A read in flight at reset is discarded.

## Configuration
- `IO_BUS_ERR_EN` defined:
  - Any access to an unmapped address sets a sticky error flag and captures `addr` into ERR.
  - ERR read at offset 10 returns `{flag, 1'b0, addr[29:0]}`.
  - Writing any value to offset 10 clears the flag.
  - The first error is held; later errors do not overwrite it.
- Undefined: offset 10 is unmapped and no error logic is built.

## Structure
- Package `io_bus_pkg` holds:
  - the I/O base word address 0x4000;
  - offset constants `OFF_TX` … `OFF_ERR`;
  - the read-select enum (`SEL_NONE`, `SEL_RAM`, `SEL_IO`).
- Sub-module `sync2`: parametrised-width 2-flop synchroniser with async reset, used for `gpio_in`.

## Test plan
- Write 0xA5 to word 0x3 with `we=4'h1`, then read it -> `rdata` = 0x000000A5 one cycle after `re`.
- From `gpio_out=0xA5`, write 0x0F to SET, then 0x81 to CLR, then 0xFF to TGL -> `gpio_out` goes 0xAF, 0x2E, 0xD1.
- Write CMP = 5 and step `ms_count` 4 -> 5 -> 5 -> `irq` rises once. Clear via word 9 while `ms_count` stays 5 -> `irq` stays 0. Step `ms_count` 6 -> 5 -> `irq` rises again.
- Read 0x4001 with `rx_empty=0`, `uart_rdata=0x41` -> `rdata` = 0x041 and `uart_rd` pulses in the following cycle.
- Read word 0x4020 -> `rdata` = 0. With `IO_BUS_ERR_EN`, a read of offset 10 then returns 0x80004020.
- Assert `reset` mid-read of RAM word 0x10 -> `rdata` = 0 next cycle and `gpio_out` = `GPIO_RESET` immediately.
